// File: rtl/lcd_wr_if.sv
// Upstream write channel into the HD44780 write engine: one byte plus
// register select, transferred on a valid/ready handshake.
interface lcd_wr_if;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_rs;
    logic [7:0] wr_data;

    modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_write_engine.sv
// HD44780 write sequencer: setup, enable strobe, then a fixed post-strobe wait.
// Define LCD_BUSY_POLL_EN to replace the fixed wait with busy-flag polling.
module lcd_write_engine #(
    parameter int SETUP_CYC      = 4,
    parameter int EN_HIGH_CYC    = 25,
    parameter int SHORT_WAIT_CYC = 2500,
    parameter int LONG_WAIT_CYC  = 82000
) (
    input  logic       Clk,
    input  logic       rst,
    lcd_wr_if.slave    wr,
    inout  wire  [7:0] LCD_DATA,
    output logic       LCD_EN,
    output logic       LCD_RW,
    output logic       LCD_RS,
    output logic       err_timeout
);
    localparam int MAX_A = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
    localparam int MAX_B = (SHORT_WAIT_CYC > LONG_WAIT_CYC) ? SHORT_WAIT_CYC : LONG_WAIT_CYC;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LAST    = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_WAIT_CYC - 1);

`ifdef LCD_BUSY_POLL_EN
    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, WAIT, POLL_SETUP, POLL_STROBE, POLL_CHECK
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE, SETUP, STROBE, WAIT
    } state_t;
    localparam logic [CW-1:0] SHORT_LAST = CW'(SHORT_WAIT_CYC - 1);
`endif

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [7:0]    data_reg;
    logic          rs_reg;
    logic          rw_reg;
    logic          en_reg;
    logic          ready_reg;

`ifdef LCD_BUSY_POLL_EN
    logic [CW-1:0] tmo_reg;
    logic          busy_reg;
    logic          err_reg;
`else
    logic          long_reg;
    logic [CW-1:0] wait_last;
    assign wait_last = long_reg ? LONG_LAST : SHORT_LAST;
`endif

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            data_reg  <= 8'h00;
            rs_reg    <= 1'b0;
            rw_reg    <= 1'b0;
            en_reg    <= 1'b0;
            ready_reg <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            tmo_reg   <= '0;
            busy_reg  <= 1'b0;
            err_reg   <= 1'b0;
`else
            long_reg  <= 1'b0;
`endif
        end else begin
`ifdef LCD_BUSY_POLL_EN
            err_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (wr.wr_valid && ready_reg) begin
                        data_reg  <= wr.wr_data;
                        rs_reg    <= wr.wr_rs;
                        rw_reg    <= 1'b0;
                        ready_reg <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= SETUP;
`ifndef LCD_BUSY_POLL_EN
                        // Clear display / return home take ~1.64 ms on the panel.
                        long_reg  <= !wr.wr_rs && (wr.wr_data[7:2] == 6'd0)
                                     && (wr.wr_data != 8'h00);
`endif
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_reg == SETUP_LAST) begin
                        cnt_reg   <= '0;
                        en_reg    <= 1'b1;
                        state_reg <= STROBE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt_reg == EN_LAST) begin
                        cnt_reg   <= '0;
                        en_reg    <= 1'b0;
                        state_reg <= WAIT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`ifdef LCD_BUSY_POLL_EN
                WAIT: begin
                    // One hold cycle with the write bus still driven, then turn it around.
                    rw_reg    <= 1'b1;
                    rs_reg    <= 1'b0;
                    cnt_reg   <= '0;
                    tmo_reg   <= '0;
                    state_reg <= POLL_SETUP;
                end
                POLL_SETUP: begin
                    if (tmo_reg != LONG_LAST) tmo_reg <= tmo_reg + 1'b1;
                    if (cnt_reg == SETUP_LAST) begin
                        cnt_reg   <= '0;
                        en_reg    <= 1'b1;
                        state_reg <= POLL_STROBE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                POLL_STROBE: begin
                    if (tmo_reg != LONG_LAST) tmo_reg <= tmo_reg + 1'b1;
                    if (cnt_reg == EN_LAST) begin
                        busy_reg  <= LCD_DATA[7];
                        cnt_reg   <= '0;
                        en_reg    <= 1'b0;
                        state_reg <= POLL_CHECK;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                POLL_CHECK: begin
                    if (tmo_reg != LONG_LAST) tmo_reg <= tmo_reg + 1'b1;
                    if (!busy_reg || tmo_reg == LONG_LAST) begin
                        err_reg   <= busy_reg;
                        rw_reg    <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg   <= '0;
                        state_reg <= POLL_SETUP;
                    end
                end
`else
                WAIT: begin
                    if (cnt_reg == wait_last) begin
                        cnt_reg   <= '0;
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign wr.wr_ready = ready_reg;
    assign LCD_EN      = en_reg;
    assign LCD_RW      = rw_reg;
    assign LCD_RS      = rs_reg;
    assign LCD_DATA    = rw_reg ? 8'hzz : data_reg;

`ifdef LCD_BUSY_POLL_EN
    assign err_timeout = err_reg;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/lcd_write_engine.md
LCD_WRITE_ENGINE -- requirements
Module: lcd_write_engine

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 4, Clk cycles that RS/RW/DATA are stable before LCD_EN rises (min 1).
REQ-002 SHALL have parameter EN_HIGH_CYC, default 25, Clk cycles that LCD_EN is held high (min 1).
REQ-003 SHALL have parameter SHORT_WAIT_CYC, default 2500, post-strobe wait for ordinary commands and data (50 us at 50 MHz).
REQ-004 SHALL have parameter LONG_WAIT_CYC, default 82000, post-strobe wait for clear/home commands (1.64 ms); also the busy-poll timeout.
REQ-005 SHALL have port Clk  in  1  system clock, 50 MHz.
REQ-006 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have port wr_valid  in  1  upstream write request.
REQ-008 SHALL have port wr_ready  out  1  engine can accept a write.
REQ-009 SHALL have port wr_rs  in  1  0 = instruction, 1 = data (CGRAM/DDRAM).
REQ-010 SHALL have port wr_data  in  8  byte to write.
REQ-011 SHALL have port LCD_DATA  inout  8  HD44780 data bus.
REQ-012 SHALL have port LCD_EN  out  1  enable strobe.
REQ-013 SHALL have port LCD_RW  out  1  0 = write, 1 = read.
REQ-014 SHALL have port LCD_RS  out  1  register select.
REQ-015 SHALL have port err_timeout  out  1  one-cycle pulse on busy-poll timeout.

Function
REQ-016 SHALL use states IDLE, SETUP, STROBE, WAIT, plus POLL_SETUP, POLL_STROBE, POLL_CHECK when the macro below is defined.
REQ-017 SHALL drive registered wr_ready=1 only in IDLE; a write is accepted on a Clk edge where wr_valid and wr_ready are both 1.
REQ-018 SHALL, on acceptance, latch wr_rs/wr_data, drive LCD_RS=wr_rs, LCD_RW=0, LCD_DATA=wr_data, deassert wr_ready, and enter SETUP.
REQ-019 SHALL hold SETUP for SETUP_CYC cycles with LCD_EN=0, then hold STROBE for EN_HIGH_CYC cycles with LCD_EN=1, then drop LCD_EN.
REQ-020 SHALL keep LCD_RS, LCD_RW, LCD_DATA unchanged from acceptance until the cycle after LCD_EN falls (hold >= 1 cycle).
REQ-021 SHALL classify a write as long when wr_rs=0, wr_data[7:2]=0, and wr_data!=0 (0x01, 0x02, 0x03); all other writes are short.
REQ-022 SHALL, without the macro, count WAIT for LONG_WAIT_CYC or SHORT_WAIT_CYC cycles, then return to IDLE.
REQ-023 SHALL reassert wr_ready exactly SETUP_CYC+EN_HIGH_CYC+wait cycles after the accepting edge; wr_valid during non-IDLE states is ignored.
REQ-024 SHALL drive LCD_DATA whenever LCD_RW=0 and tri-state it (8'hZZ) whenever LCD_RW=1.
REQ-025 SHALL size all counters to hold LONG_WAIT_CYC without wrap; counter values wrap only via explicit reload to 0.
REQ-026 SHALL hold err_timeout=0 except as given in REQ-032.

Reset
REQ-027 SHALL, while rst=0, force: state IDLE, wr_ready=0, LCD_EN=0, LCD_RW=0, LCD_RS=0, LCD_DATA driven 8'h00, err_timeout=0, counters 0.
REQ-028 SHALL set wr_ready=1 on the first Clk edge after rst deasserts.
REQ-029 SHALL abort any transfer on mid-operation reset; LCD_EN falls asynchronously and no partial write resumes.

Configuration
REQ-030 SHALL compile busy-flag polling only when macro LCD_BUSY_POLL_EN is defined; without it, fixed waits per REQ-022 apply and err_timeout is tied 0.
REQ-031 SHALL, with LCD_BUSY_POLL_EN, replace WAIT as follows: after 1 hold cycle set LCD_RW=1, LCD_RS=0, release the bus, wait SETUP_CYC cycles (POLL_SETUP), pulse LCD_EN for EN_HIGH_CYC cycles (POLL_STROBE), and sample LCD_DATA[7] on the last EN-high cycle.
REQ-032 SHALL, in POLL_CHECK, go to IDLE with LCD_RW=0 if D7=0; otherwise repeat POLL_SETUP; if LONG_WAIT_CYC cycles elapse since the first poll, pulse err_timeout for 1 cycle and go to IDLE.

Verification
REQ-033 SHALL cover: SETUP_CYC=2, EN_HIGH_CYC=3, SHORT=10, LONG=40, write rs=1 data=0x41 -> LCD_EN high cycles 3-5 after accept, RS=1, DATA=0x41, wr_ready high again at cycle 15.
REQ-034 SHALL cover: same params, write rs=0 data=0x01 -> wr_ready returns at cycle 45; write rs=0 data=0x38 -> returns at cycle 15.
REQ-035 SHALL cover: wr_valid held high for 3 back-to-back writes -> exactly 3 EN pulses, each separated by the full wait, with no write lost or duplicated.
REQ-036 SHALL cover: rst=0 asserted mid-STROBE -> LCD_EN=0 immediately and wr_ready=0; wr_ready=1 one edge after release.
REQ-037 SHALL cover, with LCD_BUSY_POLL_EN: model returns D7=1 for 2 polls then 0 -> 3 read strobes with LCD_DATA=Z and RW=1, then IDLE.
REQ-038 SHALL cover, with LCD_BUSY_POLL_EN: D7 stuck at 1 -> err_timeout pulses once, then wr_ready=1.
